// File: rtl/shared_reg_rr_arb.sv
// shared_reg_rr_arb: round-robin arbiter owning one shared register driven by load/clear/set commands
module shared_reg_rr_arb #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_i,
    input  logic [2*N-1:0] op_i,
    input  logic [N*W-1:0] d_i,
    output logic [N-1:0]   gnt_o,
    output logic [2:0]     gnt_id_o,
    output logic           busy_o,
    output logic [W-1:0]   q_o
);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [2:0]    id_q, id_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [W-1:0]  q_q, q_d;
    logic          own;
    logic [N-1:0]  others;
    logic [1:0]    own_op;
    logic [W-1:0]  own_d;

    function automatic logic [2:0] first(input logic [N-1:0] m, input logic [2:0] s);
        first = 3'd0;
        for (int k = N - 1; k >= 0; k--) begin
            if (m[(int'(s) + k) % N]) first = 3'((int'(s) + k) % N);
        end
    endfunction

    function automatic logic [2:0] nxt(input logic [2:0] g);
        nxt = (int'(g) == N - 1) ? 3'd0 : g + 3'd1;
    endfunction

    // Owner command and data are muxed through the one-hot grant so non-owner inputs never reach q
    always_comb begin
        own_op = 2'b00;
        own_d  = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_q[i]) begin
                own_op = op_i[2*i +: 2];
                own_d  = d_i[i*W +: W];
            end
        end
        own    = |(req_i & gnt_q);
        others = req_i & ~gnt_q;
    end

    // Next grant: new grant from IDLE, release or forced rotation hand over on the same edge
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        if (state_q == IDLE) begin
            if (|req_i) begin
                id_d    = first(req_i, ptr_q);
                gnt_d   = N'(1) << id_d;
                hold_d  = HW'(1);
                state_d = GRANT;
            end
        end else if (!own || (|others && hold_q == HW'(MAX_HOLD))) begin
            ptr_d = nxt(id_q);
            if (|others) begin
                id_d   = first(others, ptr_d);
                gnt_d  = N'(1) << id_d;
                hold_d = HW'(1);
            end else begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        end else if (hold_q != HW'(MAX_HOLD)) begin
            hold_d = hold_q + HW'(1);
        end
    end

    // Register update from the owner's command while it still holds its request
    always_comb begin
        q_d = q_q;
        if (state_q == GRANT && own) begin
            q_d = (own_op == 2'b01) ? own_d :
                  (own_op == 2'b10) ? '0 :
                  (own_op == 2'b11) ? '1 : q_q;
        end
    end

    // State registers; reset aborts any grant immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= 3'd0;
            ptr_q   <= 3'd0;
            hold_q  <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            q_q     <= q_d;
        end
    end

    assign gnt_o    = gnt_q;
    assign gnt_id_o = id_q;
    assign busy_o   = |gnt_q;
    assign q_o      = q_q;
endmodule

// File: tb/tb_shared_reg_rr_arb.sv
// tb_shared_reg_rr_arb: scoreboard bench with directed vectors for the shared register arbiter
module tb_shared_reg_rr_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = 4'b1111;
    logic [7:0]  op = 8'h00;
    logic [31:0] d = 32'h0;
    logic [3:0]  gnt;
    logic [2:0]  gnt_id;
    logic        busy;
    logic [7:0]  q;

    typedef struct packed {
        logic [3:0] g;
        logic [2:0] id;
        logic [7:0] q;
    } exp_t;

    exp_t  exp_q[$];
    string nm_q[$];
    int    tests = 0;
    int    fails = 0;

    shared_reg_rr_arb #(.N(4), .W(8), .MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .op_i(op), .d_i(d),
        .gnt_o(gnt), .gnt_id_o(gnt_id), .busy_o(busy), .q_o(q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input int act, input int want);
        tests++;
        if (act != want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, want, $time);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [7:0] o, input logic [31:0] dd,
                        input logic [3:0] eg, input logic [2:0] eid, input logic [7:0] eq,
                        input string n);
        exp_t e;
        req = r;
        op  = o;
        d   = dd;
        e.g = eg;
        e.id = eid;
        e.q = eq;
        exp_q.push_back(e);
        nm_q.push_back(n);
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t  e;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                chk({n, ".gnt"}, int'(gnt), int'(e.g));
                chk({n, ".busy"}, int'(busy), int'(|e.g));
                chk({n, ".q"}, int'(q), int'(e.q));
                if (|e.g) chk({n, ".gnt_id"}, int'(gnt_id), int'(e.id));
            end
        end
    end

    initial begin : stim
        int idx;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.q", int'(q), 0);
        chk("rst.gnt", int'(gnt), 0);
        chk("rst.busy", int'(busy), 0);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            idx = ((k - 1) / 4) % 4;
            step(4'b1111, 8'h00, 32'h0, 4'(1 << idx), 3'(idx), 8'h00, "rr");
        end
        step(4'b0000, 8'h00, 32'h0, 4'b0000, 3'd0, 8'h00, "rr_idle");

        step(4'b0100, 8'h00, 32'h0, 4'b0100, 3'd2, 8'h00, "t2_gnt");
        step(4'b0100, 8'h10, 32'h00A5_0000, 4'b0100, 3'd2, 8'hA5, "t2_load");
        step(4'b0100, 8'h20, 32'h00A5_0000, 4'b0100, 3'd2, 8'h00, "t2_clr");
        step(4'b0100, 8'h30, 32'h0, 4'b0100, 3'd2, 8'hFF, "t2_set");
        step(4'b0000, 8'h10, 32'h0, 4'b0000, 3'd0, 8'hFF, "t2_rel");

        for (int k = 0; k < 10; k++)
            step(4'b0001, 8'h00, 32'h0, 4'b0001, 3'd0, 8'hFF, "t4_solo");
        step(4'b1000, 8'h00, 32'h0, 4'b1000, 3'd3, 8'hFF, "t4_handoff");
        step(4'b1000, 8'h00, 32'h0, 4'b1000, 3'd3, 8'hFF, "t4_keep3");
        step(4'b0110, 8'h00, 32'h0, 4'b0010, 3'd1, 8'hFF, "t4_wrap");
        step(4'b0100, 8'h00, 32'h0, 4'b0100, 3'd2, 8'hFF, "t4_next");
        step(4'b0000, 8'h00, 32'h0, 4'b0000, 3'd0, 8'hFF, "t4_idle");

        step(4'b0001, 8'h02, 32'h0, 4'b0001, 3'd0, 8'hFF, "t5_gnt");
        step(4'b0001, 8'h02, 32'h0, 4'b0001, 3'd0, 8'h00, "t5_clr");
        step(4'b0011, 8'h0C, 32'h0, 4'b0001, 3'd0, 8'h00, "t5_nonowner");
        step(4'b0011, 8'h0C, 32'h0, 4'b0001, 3'd0, 8'h00, "t5_nonowner2");
        step(4'b0011, 8'h0D, 32'h0000_FF3C, 4'b0010, 3'd1, 8'h3C, "t5_rotate");
        step(4'b0010, 8'h00, 32'h0, 4'b0010, 3'd1, 8'h3C, "t5_keep1");
        step(4'b0010, 8'h04, 32'h0000_5A00, 4'b0010, 3'd1, 8'h5A, "t6_load");

        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async.q", int'(q), 0);
        chk("t6_async.gnt", int'(gnt), 0);
        chk("t6_async.busy", int'(busy), 0);
        @(posedge clk);
        #1;
        chk("t6_hold.q", int'(q), 0);
        chk("t6_hold.gnt", int'(gnt), 0);
        #1;
        rst_n = 1'b1;
        step(4'b0010, 8'h04, 32'h0000_7700, 4'b0010, 3'd1, 8'h00, "t6_regrant");
        step(4'b0010, 8'h04, 32'h0000_7700, 4'b0010, 3'd1, 8'h77, "t6_load");

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
